regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the RISC-V core: 2 combinational read ports,
//  1 synchronous write port, write-to-read bypass and hardwired x0.
//  Adds a per-register busy scoreboard for the issue stage and a multi-cycle
//  clear sequence after reset. Sits between decode/issue and the writeback stage.
// PARAMETERS
//  XLEN    32   data width of each register
//  NREG    32   number of architectural registers (power of 2, >= 2)
//  AW      $clog2(NREG)  register index width (derived, do not override)
//  BYPASS  1    1: a same-cycle write is forwarded to A/B; 0: reads return stored value
// PORTS
//  CLK         in   1        clock, all state updates on rising edge
//  rstControl  in   1        synchronous reset, active-high
//  rs          in   AW       read index, port A
//  rt          in   AW       read index, port B
//  A           out  XLEN     read data, port A (combinational)
//  B           out  XLEN     read data, port B (combinational)
//  WE          in   1        writeback enable
//  rd          in   AW       writeback index
//  writeBack   in   XLEN     writeback data
//  issue_valid in   1        issue stage presents an instruction
//  issue_rs    in   AW       source index 1 of issuing instr (0 if unused)
//  issue_rt    in   AW       source index 2 of issuing instr (0 if unused)
//  issue_rd    in   AW       destination of issuing instr (0 if none)
//  issue_ready out  1        instruction may issue this cycle (combinational)
//  flush       in   1        pipeline flush: clear all busy bits
//  busy_vec    out  NREG     current busy bits (registered), bit 0 always 0
//  init_done   out  1        1 once clear sequence complete (registered)
// BEHAVIOUR
//  FSM: INIT, RUN. rstControl=1 at an edge: state<=INIT, idx<=0, busy_vec<=0, init_done<=0.
//  INIT: each cycle regs[idx]<=0, idx<=idx+1; after clearing idx=NREG-1 -> RUN, init_done<=1.
//   INIT lasts exactly NREG cycles after reset release; reset asserted mid-INIT restarts at idx=0.
//   In INIT: A=B=0, issue_ready=0, WE and issue ignored; flush ignored.
//  RUN: reset asserted again -> INIT (registers re-cleared, busy cleared).
//  Read: A = 0 if rs==0 or state==INIT; else if BYPASS && WE && rd==rs -> writeBack;
//   else regs[rs]. B identical with rt. Zero-cycle latency.
//  Write: at edge, if RUN && WE && rd!=0 -> regs[rd]<=writeBack. Writes to x0 discarded.
//  Busy clear: RUN && WE && rd!=0 -> busy[rd]<=0 (write to non-busy reg is legal, busy stays 0).
//  busy_eff[i] = busy[i] && !(WE && rd==i); busy_eff[0]=0.
//  issue_ready = RUN && !flush && !busy_eff[issue_rs] && !busy_eff[issue_rt] && !busy_eff[issue_rd].
//   Depends only on state, busy, flush and the issue_*/WE/rd inputs, not on issue_valid.
//  Issue accept: issue_valid && issue_ready -> busy[issue_rd]<=1 if issue_rd!=0.
//  Simultaneous clear (WE,rd=r) and set (issue_rd=r) same edge: set wins, busy[r]=1.
//  flush=1 in RUN: all busy bits <=0 at edge, overrides same-cycle set; register writes still occur.
//  Priority per edge: rstControl > flush > issue set > writeback clear.
//  Reset values: busy_vec=0, init_done=0; A/B=0 while in INIT; issue_ready=0 while in INIT.
// TESTING
//  1 Reset 2 cycles, release -> init_done=0 for exactly NREG cycles then 1; all reads return 0;
//    pre-loaded regs (from a write before reset) read 0.
//  2 WE=1 rd=0 wb=FFFFFFFF, then read rs=0 -> A=0; WE=1 rd=1 wb=AAAAAAAA with rs=1 same cycle
//    -> A=AAAAAAAA (BYPASS=1) and next cycle; with BYPASS=0 A=0 in write cycle, AAAAAAAA after.
//  3 Issue rd=5 -> busy_vec[5]=1; issue rs=5 -> issue_ready=0; WE rd=5 wb=12345678 same cycle
//    -> issue_ready=1 and B/A bypass 12345678; after edge busy_vec[5]=0.
//  4 Same edge: WE rd=7 clears, issue_rd=7 accepted -> busy_vec[7]=1 afterwards.
//  5 Set busy on r3,r4, assert flush with issue_rd=6 -> busy_vec=0 after edge, issue_ready=0 that cycle.
//  6 Assert rstControl mid-INIT (idx=10) and in RUN with busy bits set -> idx restarts,
//    busy_vec=0, init_done=0, full NREG-cycle INIT repeats, prior data reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with bypass, hardwired x0, issue busy scoreboard
// and a sequential clear of every register after reset.
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = $clog2(NREG),
   parameter bit BYPASS = 1'b1
) (
   input  logic            CLK,
   input  logic            rstControl,
   input  logic [AW-1:0]   rs,
   input  logic [AW-1:0]   rt,
   output logic [XLEN-1:0] A,
   output logic [XLEN-1:0] B,
   input  logic            WE,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] writeBack,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rs,
   input  logic [AW-1:0]   issue_rt,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic            flush,
   output logic [NREG-1:0] busy_vec,
   output logic            init_done
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic [AW-1:0]   r_idx, w_idx_nxt;
   logic            r_init_done, w_init_done_nxt;
   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy, w_busy_nxt, w_busy_eff;
   logic            w_run, w_wr, w_accept;

   assign w_run    = (r_state == S_RUN);
   assign w_wr     = w_run && WE && (rd != '0);
   assign w_accept = issue_valid && issue_ready && (issue_rd != '0);

   // state, clear index and init_done registers
   always_ff @(posedge CLK) begin
      if (rstControl) begin
         r_state     <= S_INIT;
         r_idx       <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   // walk the clear index through every register, then run
   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_init_done_nxt = r_init_done;
      if (r_state == S_INIT) begin
         w_idx_nxt = r_idx + 1'b1;
         if (r_idx == AW'(NREG - 1)) begin
            w_state_nxt     = S_RUN;
            w_init_done_nxt = 1'b1;
         end
      end
   end

   // storage: zeroed one entry per cycle in INIT, written back in RUN
   always_ff @(posedge CLK) begin
      if (!rstControl) begin
         if (r_state == S_INIT) begin
            r_regs[r_idx] <= '0;
         end else if (w_wr) begin
            r_regs[rd] <= writeBack;
         end
      end
   end

   // read port A with optional same-cycle forwarding
   always_comb begin
      A = '0;
      if (w_run && (rs != '0)) begin
         if (BYPASS && WE && (rd == rs)) A = writeBack;
         else                            A = r_regs[rs];
      end
   end

   // read port B with optional same-cycle forwarding
   always_comb begin
      B = '0;
      if (w_run && (rt != '0)) begin
         if (BYPASS && WE && (rd == rt)) B = writeBack;
         else                            B = r_regs[rt];
      end
   end

   // busy bits as seen by issue, with this cycle's writeback released
   always_comb begin
      w_busy_eff = r_busy;
      for (int i = 1; i < NREG; i++) begin
         if (WE && (rd == AW'(i))) w_busy_eff[i] = 1'b0;
      end
      w_busy_eff[0] = 1'b0;
   end

   assign issue_ready = w_run && !flush
                        && !w_busy_eff[issue_rs]
                        && !w_busy_eff[issue_rt]
                        && !w_busy_eff[issue_rd];

   // scoreboard update: flush, then issue set over writeback clear
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_run) begin
         if (flush) begin
            w_busy_nxt = '0;
         end else begin
            if (w_wr)     w_busy_nxt[rd]       = 1'b0;
            if (w_accept) w_busy_nxt[issue_rd] = 1'b1;
         end
      end
      w_busy_nxt[0] = 1'b0;
   end

   // scoreboard register
   always_ff @(posedge CLK) begin
      if (rstControl) r_busy <= '0;
      else            r_busy <= w_busy_nxt;
   end

   assign busy_vec  = r_busy;
   assign init_done = r_init_done;

endmodule
